// File: rtl/logic_alu_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | logic_alu_arbiter_pkg : op encodings and FSM state for the arbiter    |
// | rev 1.0                                                                |
// +----------------------------------------------------------------------+
package logic_alu_arbiter_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/logic_alu_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : combinational round-robin picker, search from last+1 upward |
// | rev 1.0                                                                |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);

  always_comb begin
    int idx;
    idx          = 0;
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!any && req[idx]) begin
        any               = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = idx[ID_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/logic_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | logic_alu_arbiter : round-robin share of one AND/OR/XOR/NOT unit      |
// | rev 1.0                                                                |
// +----------------------------------------------------------------------+
module logic_alu_arbiter
  import logic_alu_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ*2-1:0] req_op,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [ID_W-1:0]    out_id,
  input  logic               out_ready,
  output logic [15:0]        ops_done
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       ops_done_q, ops_done_d;

  logic [N_REQ-1:0]  grant_onehot;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic              can_accept;
  logic              handshake;
  logic [W-1:0]      sel_a, sel_b, alu_res;
  logic [1:0]        sel_op;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr_pick (
    .req          (req_valid),
    .last         (last_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  assign can_accept = (state_q == IDLE) || out_ready;
  assign req_ready  = (!rst && can_accept && grant_any) ? grant_onehot : '0;
  assign handshake  = |(req_valid & req_ready);

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = OP_AND;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_onehot[i]) begin
        sel_a  = req_a[i*W +: W];
        sel_b  = req_b[i*W +: W];
        sel_op = req_op[i*2 +: 2];
      end
    end
    case (sel_op)
      OP_AND:  alu_res = sel_a & sel_b;
      OP_OR:   alu_res = sel_a | sel_b;
      OP_XOR:  alu_res = sel_a ^ sel_b;
      default: alu_res = ~sel_a;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_valid_d = out_valid_q;
    ops_done_d  = (out_valid_q && out_ready) ? 16'(ops_done_q + 16'd1) : ops_done_q;
    // A handshake wins over retirement, so back-to-back results keep out_valid high.
    if (handshake) begin
      state_d     = FULL;
      last_d      = grant_idx;
      out_data_d  = alu_res;
      out_id_d    = grant_idx;
      out_valid_d = 1'b1;
    end else if (state_q == FULL && out_ready) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= ID_W'(N_REQ - 1);
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign ops_done  = ops_done_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_logic_alu_arbiter : directed self-checking bench for the arbiter   |
// | rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_logic_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  req_op;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_ready;
  logic [15:0] ops_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_alu_arbiter #(.N_REQ(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .ops_done  (ops_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op);
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_op[i*2 +: 2] = op;
    req_valid[i]     = 1'b1;
  endtask

  logic [7:0] exp_res [4];

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    out_ready = 1'b1;
    exp_res[0] = 8'h11;  // 1F & F1
    exp_res[1] = 8'h3F;  // 33 | 0F
    exp_res[2] = 8'hFF;  // 55 ^ AA
    exp_res[3] = 8'hC3;  // ~3C

    // reset; a pending request must not be granted while rst is high
    set_req(0, 8'hF0, 8'h3C, 2'b00);
    #1;
    check("ready_in_rst", {28'd0, req_ready}, 32'h0);
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'h0);
    check("rst_out_data", {24'd0, out_data}, 32'h0);
    check("rst_out_id", {30'd0, out_id}, 32'h0);
    check("rst_ops_done", {16'd0, ops_done}, 32'h0);

    // single request from requester 0
    rst = 1'b0;
    #1;
    check("t1_ready", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid = '0;
    check("t1_valid", {31'd0, out_valid}, 32'h1);
    check("t1_data", {24'd0, out_data}, 32'h30);
    check("t1_id", {30'd0, out_id}, 32'h0);
    check("t1_ops_before", {16'd0, ops_done}, 32'h0);
    tick();
    check("t1_ops_after", {16'd0, ops_done}, 32'h1);
    check("t1_idle", {31'd0, out_valid}, 32'h0);

    // all four ops from requester 2, back-to-back
    set_req(2, 8'hA5, 8'h0F, 2'b00);
    #1;
    check("t2_ready0", {28'd0, req_ready}, 32'h4);
    tick();
    check("t2_and", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h05});
    check("t2_id0", {30'd0, out_id}, 32'h2);
    req_op[5:4] = 2'b01;
    #1;
    check("t2_ready1", {28'd0, req_ready}, 32'h4);
    tick();
    check("t2_or", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hAF});
    req_op[5:4] = 2'b10;
    tick();
    check("t2_xor", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hAA});
    req_op[5:4] = 2'b11;
    tick();
    check("t2_not", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h5A});
    check("t2_id3", {30'd0, out_id}, 32'h2);
    req_valid = '0;
    tick();
    check("t2_ops", {16'd0, ops_done}, 32'h5);

    // reset, then all four requesters continuously valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t3_ops_rst", {16'd0, ops_done}, 32'h0);
    set_req(0, 8'h1F, 8'hF1, 2'b00);
    set_req(1, 8'h33, 8'h0F, 2'b01);
    set_req(2, 8'h55, 8'hAA, 2'b10);
    set_req(3, 8'h3C, 8'h00, 2'b11);
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("t3_ready%0d", k), {28'd0, req_ready}, 32'h1 << (k % 4));
      tick();
      check($sformatf("t3_id%0d", k), {30'd0, out_id}, k % 4);
      check($sformatf("t3_data%0d", k), {23'd0, out_valid, out_data},
            {23'd0, 1'b1, exp_res[k % 4]});
    end
    req_valid = '0;
    tick();
    check("t3_ops", {16'd0, ops_done}, 32'h8);
    check("t3_idle", {31'd0, out_valid}, 32'h0);

    // backpressure
    set_req(2, 8'h81, 8'h42, 2'b01);
    tick();
    req_valid = '0;
    check("t4_first", {24'd0, out_data}, 32'hC3);
    out_ready = 1'b0;
    set_req(1, 8'hF0, 8'h00, 2'b11);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t4_ready_bp%0d", k), {28'd0, req_ready}, 32'h0);
      tick();
      check($sformatf("t4_hold%0d", k), {21'd0, out_valid, out_id, out_data},
            {21'd0, 1'b1, 2'd2, 8'hC3});
    end
    check("t4_ops_hold", {16'd0, ops_done}, 32'h8);
    out_ready = 1'b1;
    #1;
    check("t4_ready_rel", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid = '0;
    check("t4_new", {21'd0, out_valid, out_id, out_data}, {21'd0, 1'b1, 2'd1, 8'h0F});
    check("t4_ops_retire", {16'd0, ops_done}, 32'h9);
    tick();
    check("t4_ops_end", {16'd0, ops_done}, 32'hA);

    // reset while FULL with out_ready low
    set_req(3, 8'h0F, 8'h00, 2'b11);
    tick();
    check("t5_full", {21'd0, out_valid, out_id, out_data}, {21'd0, 1'b1, 2'd3, 8'hF0});
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    check("t5_ready_rst", {28'd0, req_ready}, 32'h0);
    tick();
    check("t5_valid", {31'd0, out_valid}, 32'h0);
    check("t5_ops", {16'd0, ops_done}, 32'h0);
    rst       = 1'b0;
    out_ready = 1'b1;
    set_req(0, 8'hCC, 8'hAA, 2'b10);
    #1;
    check("t5_ready_prio", {28'd0, req_ready}, 32'h1);
    tick();
    check("t5_first", {21'd0, out_valid, out_id, out_data}, {21'd0, 1'b1, 2'd0, 8'h66});

    // ops_done wrap: single requester streams one result per cycle
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 4'b0001;
    repeat (65535) tick();
    check("t6_fffe", {16'd0, ops_done}, 32'hFFFE);
    tick();
    check("t6_ffff", {16'd0, ops_done}, 32'hFFFF);
    tick();
    check("t6_wrap", {16'd0, ops_done}, 32'h0);
    check("t6_valid", {31'd0, out_valid}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
